// File: rtl/a3_div_pkg.sv
// Shared types and widths for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a3_div_pkg;

    localparam int N_W      = 8;  // dividend / quotient width
    localparam int D_W      = 4;  // divisor / published remainder width
    localparam int R_W      = 5;  // partial remainder width (one guard bit)
    localparam int ITER_DEF = 8;  // one iteration per dividend bit

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/a3_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider runs.
module a3_div_step
    import a3_div_pkg::*;
(
    input  logic [R_W-1:0] rem_i,   // partial remainder from previous iteration
    input  logic           bit_i,   // next dividend bit, MSB first
    input  logic [D_W-1:0] div_i,   // divisor
    output logic [R_W-1:0] rem_o,   // partial remainder after this iteration
    output logic           q_o      // quotient bit produced by this iteration
);

    logic [R_W-1:0] shifted;
    logic [R_W-1:0] div_ext;

    // Shift the remainder left, bring in the dividend bit, and keep the
    // subtraction only when it does not go negative (5-bit compare).
    always_comb begin
        shifted = {rem_i[R_W-2:0], bit_i};
        div_ext = {1'b0, div_i};
        q_o     = 1'b0;
        rem_o   = shifted;
        if (shifted >= div_ext) begin
            q_o   = 1'b1;
            rem_o = shifted - div_ext;
        end
    end

endmodule

// File: rtl/tt_um_a3_seq_divider.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: done rises ITER cycles after the edge that accepts start; start is ignored while busy.
// Build option: DIV_ZERO_DETECT_EN short-circuits D=0 to a one-cycle result with dz set.
module tt_um_a3_seq_divider
    import a3_div_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    // Input field decode
    logic [D_W-1:0] div_in;
    logic           start;
    logic           sel;

    assign div_in = uio_in[D_W-1:0];
    assign start  = uio_in[4];
    assign sel    = uio_in[5];

    // ena is always high on the carrier board; upper bidir bits carry nothing
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:6]};

    // State and datapath registers
    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] n_q,     n_d;      // dividend, shifted left each iteration
    logic [D_W-1:0] d_q,     d_d;      // divisor, frozen for the whole run
    logic [R_W-1:0] rem_q,   rem_d;    // partial remainder
    logic [N_W-1:0] qsh_q,   qsh_d;    // quotient bits collected so far
    logic [N_W-1:0] q_q,     q_d;      // published quotient
    logic [D_W-1:0] r_q,     r_d;      // published remainder
    logic           dz_q,    dz_d;

    logic [R_W-1:0] step_rem;
    logic           step_q;

    // Single shared iteration datapath
    a3_div_step u_step (
        .rem_i (rem_q),
        .bit_i (n_q[N_W-1]),
        .div_i (d_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Next-state logic: accept start when not running, iterate while running,
    // publish Q/R only on the final iteration so results hold during a run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        d_d     = d_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d     = ui_in;
                    d_d     = div_in;
                    rem_d   = '0;
                    qsh_d   = '0;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    // Divide by zero: skip iterating and publish the same
                    // result the full run would produce, flagged with dz.
                    if (div_in == '0) begin
                        q_d     = '1;
                        r_d     = ui_in[D_W-1:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                n_d   = {n_q[N_W-2:0], 1'b0};
                rem_d = step_rem;
                qsh_d = {qsh_q[N_W-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    q_d     = {qsh_q[N_W-2:0], step_q};
                    r_d     = step_rem[D_W-1:0];
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any run and clears published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            qsh_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Status flags follow the state directly; done stays up for as long as DONE lasts
    logic busy;
    logic done;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // Output muxing; sel only steers uo_out and never touches state
    always_comb begin
        uo_out = q_q;
        if (sel) begin
            uo_out = {busy, done, dz_q, 1'b0, r_q};
        end
    end

    assign uio_out = {busy, done, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: doc/tt_um_a3_seq_divider.md
TT_UM_A3_SEQ_DIVIDER -- requirements
Module: tt_um_a3_seq_divider

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all state.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port ena, input, 1, always 1 when powered; functionally ignored.
REQ-004 SHALL have port ui_in, input, 8, dividend N[7:0].
REQ-005 SHALL have port uio_in, input, 8; [3:0] divisor D, [4] start, [5] sel; [7:6] unused.
REQ-006 SHALL have port uo_out, output, 8; sel=0 gives quotient Q[7:0]; sel=1 gives {busy, done, dz, 1'b0, R[3:0]}.
REQ-007 SHALL have port uio_out, output, 8; [7] busy, [6] done, [5:0] = 0.
REQ-008 SHALL have port uio_oe, output, 8, constant 8'b1100_0000.
REQ-009 SHALL have parameter ITER, default 8, meaning divide iterations (= dividend width).

Function
REQ-010 SHALL compute unsigned Q = N / D and R = N mod D, with Q 8 bits and R 4 bits, using restoring division, one quotient bit per cycle, MSB first.
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture N and D, clear done and dz, set busy, and enter RUN.
REQ-013 RUN SHALL last exactly ITER cycles; on the ITER-th edge, Q/R SHALL be written, busy=0, done=1, state goes to DONE.
REQ-014 Start latency SHALL be fixed: done is first seen high 8 cycles after the edge that sampled start.
REQ-015 start SHALL be ignored while in RUN; operands SHALL NOT change mid-operation.
REQ-016 Q and R output registers SHALL update only at completion and hold the previous result during RUN.
REQ-017 done SHALL be sticky in DONE until the next accepted start; start held high in DONE SHALL restart every completion (back-to-back operations).
REQ-018 The partial-remainder register SHALL be 5 bits wide; the trial subtraction SHALL use 5-bit compare against {1'b0,D}.
REQ-019 D=0 without the detect feature SHALL run the full 8 cycles and yield Q=8'hFF, R=N[3:0], dz=0.
REQ-020 sel SHALL be purely combinational on uo_out and SHALL NOT affect state.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, Q=0, R=0, busy=0, done=0, dz=0, and iteration counter=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation and publish no result.
REQ-023 After rst_n deassertion, the first accepted start SHALL behave identically to a start issued after power-up.

Configuration
REQ-024 Macro DIV_ZERO_DETECT_EN defined: a start with D=0 SHALL go to DONE in 1 cycle with Q=8'hFF, R=N[3:0], dz=1.
REQ-025 Macro DIV_ZERO_DETECT_EN undefined: dz SHALL be constant 0 and D=0 SHALL follow REQ-019; no other behaviour differs.

Structure
REQ-026 Package a3_div_pkg SHALL hold the FSM state enum, the widths (N_W=8, D_W=4, R_W=5), and ITER_DEF=8.
REQ-027 Sub-module a3_div_step SHALL be combinational: inputs partial remainder, next dividend bit, and divisor; outputs next remainder and quotient bit. It is instantiated once and reused each cycle.
REQ-028 The top level SHALL contain only the FSM, counter, operand/shift registers, and output muxing.

Verification
REQ-029 N=200, D=7, start for 1 cycle -> done after 8 cycles; Q=0x1C, R=4; busy high for exactly 8 cycles.
REQ-030 N=255, D=15 -> Q=0x11, R=0; N=9, D=10 -> Q=0, R=9; N=0, D=1 -> Q=0, R=0.
REQ-031 N=0xAB, D=0 -> with the macro: done after 1 cycle, Q=0xFF, R=0xB, dz=1; without the macro: done after 8 cycles, same Q/R, dz=0.
REQ-032 Start N=200, D=7, then change ui_in/uio_in and pulse start during RUN -> result is still Q=0x1C, R=4 at cycle 8.
REQ-033 Assert rst_n low at RUN cycle 4 -> all outputs 0 and state IDLE; a fresh start of 100/3 then gives Q=33, R=1.
REQ-034 Hold start high across two operations -> second result appears 8 cycles after the first done; a sel toggle changes only uo_out.
